// File: rtl/rgb_stream_packer.sv
// Packs 24-bit {r,g,b} pixels into a 32-bit AXI4-Stream (4 pixels -> 3 words).
// Define RGB_STREAM_PACKER_STATS_EN to add frame_count/err_count outputs.
module rgb_stream_packer #(
    parameter int X_SIZE    = 640,
    parameter int CNT_WIDTH = 16
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        valid_int,
    input  logic        sof,
    input  logic        eol,
    output logic        in_stream_ready,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    output logic        out_stream_tuser,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready
`ifdef RGB_STREAM_PACKER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] err_count
`endif
);

    typedef enum logic {RUN, FLUSH} state_t;

    if (X_SIZE < 1 || X_SIZE >= (2 ** CNT_WIDTH)) begin : g_bad_size
        $error("X_SIZE must fit in CNT_WIDTH bits");
    end

    state_t      state, state_nx;
    logic [1:0]  cnt, cnt_nx;
    logic [23:0] acc, acc_nx;
    logic        pend_sof, pend_nx;
    logic [23:0] pix;
    logic [1:0]  ce;
    logic [47:0] cat;
    logic [2:0]  t;
    logic        free, accept, load;
    logic [31:0] data_nx;
    logic [3:0]  keep_nx;
    logic        last_nx, user_nx;

    assign pix    = {r, g, b};
    assign free   = !out_stream_tvalid || out_stream_tready;
    assign accept = valid_int && in_stream_ready;
    assign in_stream_ready = (state == RUN) && free && !areset;

    // Residual bytes sit below the new pixel; a sof pixel drops them.
    always_comb begin
        ce = sof ? 2'd0 : cnt;
        case (ce)
            2'd0:    cat = {24'd0, pix};
            2'd1:    cat = {16'd0, pix, acc[7:0]};
            2'd2:    cat = {8'd0, pix, acc[15:0]};
            default: cat = {pix, acc};
        endcase
        t = 3'd3 + {1'b0, ce};
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        acc_nx   = acc;
        pend_nx  = pend_sof;
        load     = 1'b0;
        data_nx  = '0;
        keep_nx  = '0;
        last_nx  = 1'b0;
        user_nx  = 1'b0;
        case (state)
            RUN: begin
                if (accept) begin
                    if (t[2]) begin
                        load    = 1'b1;
                        data_nx = cat[31:0];
                        keep_nx = 4'hF;
                        user_nx = pend_sof || sof;
                        pend_nx = 1'b0;
                        acc_nx  = {8'd0, cat[47:32]};
                        cnt_nx  = t[1:0];
                        if (eol && t[1:0] == 2'd0)
                            last_nx = 1'b1;
                        else if (eol)
                            state_nx = FLUSH;
                    end else if (eol) begin
                        load    = 1'b1;
                        data_nx = {8'd0, cat[23:0]};
                        keep_nx = 4'h7;
                        last_nx = 1'b1;
                        user_nx = pend_sof || sof;
                        pend_nx = 1'b0;
                        cnt_nx  = 2'd0;
                        acc_nx  = '0;
                    end else begin
                        acc_nx  = cat[23:0];
                        cnt_nx  = 2'd3;
                        pend_nx = pend_sof || sof;
                    end
                end
            end
            FLUSH: begin
                if (free) begin
                    load     = 1'b1;
                    data_nx  = {8'd0, acc};
                    keep_nx  = (cnt == 2'd2) ? 4'h3 : 4'h1;
                    last_nx  = 1'b1;
                    user_nx  = pend_sof;
                    pend_nx  = 1'b0;
                    cnt_nx   = 2'd0;
                    acc_nx   = '0;
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= RUN;
            cnt      <= 2'd0;
            acc      <= '0;
            pend_sof <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            acc      <= acc_nx;
            pend_sof <= pend_nx;
        end
    end

    // Single output stage; loads only when free, so stalls hold everything.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_stream_tvalid <= 1'b0;
            out_stream_tdata  <= '0;
            out_stream_tkeep  <= '0;
            out_stream_tlast  <= 1'b0;
            out_stream_tuser  <= 1'b0;
        end else if (load) begin
            out_stream_tvalid <= 1'b1;
            out_stream_tdata  <= data_nx;
            out_stream_tkeep  <= keep_nx;
            out_stream_tlast  <= last_nx;
            out_stream_tuser  <= user_nx;
        end else if (out_stream_tready) begin
            out_stream_tvalid <= 1'b0;
        end
    end

`ifdef RGB_STREAM_PACKER_STATS_EN
    logic [CNT_WIDTH-1:0] line_cnt, line_cur;
    logic                 line_err;

    always_comb begin
        line_cur = (sof ? '0 : line_cnt) + CNT_WIDTH'(1);
        line_err = (eol && line_cur != CNT_WIDTH'(X_SIZE))
                || (sof && cnt != 2'd0);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            line_cnt    <= '0;
            err_count   <= '0;
            frame_count <= '0;
        end else begin
            if (accept) begin
                line_cnt <= eol ? '0 : line_cur;
                if (line_err)
                    err_count <= err_count + CNT_WIDTH'(1);
            end
            if (out_stream_tvalid && out_stream_tready && out_stream_tuser)
                frame_count <= frame_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
